// File: rtl/avl_frame_writer_pkg.sv
// Shared definitions for the LPDDR2 frame capture path: Avalon widths, pixel packing, FSM states.
package avl_frame_writer_pkg;

    localparam int unsigned AVL_AW = 27;
    localparam int unsigned AVL_DW = 32;
    localparam int unsigned PIX_W  = 24;

    localparam logic [2:0] AVL_BURSTCOUNT = 3'b001;

    // 1920x1080; the video generator reads back the same number of words.
    localparam int unsigned FRAME_WORDS_1080P = 1920 * 1080;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DRAIN,
        DONE
    } fw_state_e;

    function automatic logic [AVL_DW-1:0] pack_pixel(input logic [PIX_W-1:0] pix);
        return {8'h00, pix};
    endfunction

endpackage

// File: rtl/avl_wr_fifo.sv
// Single-clock pixel FIFO with a registered read port (data valid the cycle after pop).
module avl_wr_fifo
    import avl_frame_writer_pkg::*;
#(
    parameter int unsigned FIFO_AW = 6,
    parameter int unsigned DW      = PIX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [DW-1:0]      mem_q [(1 << FIFO_AW)];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [DW-1:0]      rd_data_q;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (count_q == DEPTH);
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q  <= rd_ptr_q + FIFO_AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/avl_frame_writer.sv
// Captures one frame from the pixel stream and writes it to LPDDR2 via Avalon write port 0.
module avl_frame_writer
    import avl_frame_writer_pkg::*;
#(
    parameter logic [AVL_AW-1:0] BASE_ADDR   = '0,
    parameter int unsigned       FRAME_WORDS = FRAME_WORDS_1080P,
    parameter int unsigned       FIFO_AW     = 6
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              local_init_done,
    input  logic              avl_waitrequest_n,
    output logic [AVL_AW-1:0] avl_address,
    output logic [AVL_DW-1:0] avl_writedata,
    output logic              avl_write,
    output logic              avl_burstbegin,
    output logic [2:0]        avl_size,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    fw_state_e         state_q, state_d;
    logic [31:0]       pix_cnt_q, pix_cnt_d;
    logic [AVL_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic              overflow_q, overflow_d;
    logic              avl_write_q, avl_write_d;
    logic              burstbegin_q, burstbegin_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PIX_W-1:0]  fifo_rd_data;

    logic              start_ok;
    logic              last_pix;
    logic              wr_done;

    assign start_ok = iSTART && local_init_done && ((state_q == IDLE) || (state_q == DONE));
    assign last_pix = ((pix_cnt_q + 32'd1) == FRAME_WORDS);
    assign wr_done  = avl_write_q && avl_waitrequest_n;
    // Load the output register whenever it is free or being released this cycle.
    assign fifo_pop = !fifo_empty && (!avl_write_q || avl_waitrequest_n);

    avl_wr_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (PIX_W)
    ) u_fifo (
        .clk       (iCLK),
        .rst_n     (iRST_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (pix_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d    = WAIT_SOF;
                    pix_cnt_d  = '0;
                    overflow_d = 1'b0;
                    fifo_flush = 1'b1;
                end
            end
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    fifo_push = 1'b1;
                    pix_cnt_d = 32'd1;
                    state_d   = (FRAME_WORDS == 1) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (pix_valid) begin
                    pix_cnt_d = pix_cnt_q + 32'd1;
                    // Dropped pixels still count towards the frame but take no address.
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                    if (last_pix) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !avl_write_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        avl_write_d  = avl_write_q;
        burstbegin_d = fifo_pop;
        if (start_ok) begin
            wr_cnt_d = '0;
        end else if (wr_done) begin
            wr_cnt_d = wr_cnt_q + AVL_AW'(1);
        end
        if (fifo_pop) begin
            avl_write_d = 1'b1;
        end else if (wr_done) begin
            avl_write_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            overflow_q   <= 1'b0;
            avl_write_q  <= 1'b0;
            burstbegin_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            overflow_q   <= overflow_d;
            avl_write_q  <= avl_write_d;
            burstbegin_q <= burstbegin_d;
        end
    end

    // Address tracks completed writes, so it is stable for the whole stall.
    assign avl_address    = BASE_ADDR + wr_cnt_q;
    assign avl_writedata  = pack_pixel(fifo_rd_data);
    assign avl_write      = avl_write_q;
    assign avl_burstbegin = burstbegin_q;
    assign avl_size       = AVL_BURSTCOUNT;
    assign busy           = (state_q == WAIT_SOF) || (state_q == CAPTURE) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_avl_frame_writer.sv
// Scoreboard bench: A (deep FIFO) covers capture, stalls, restart; B (4-deep FIFO) covers overflow.
module tb_avl_frame_writer;

    localparam logic [26:0] BASE = 27'h100;
    localparam int          NPIX = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        init_done = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof   = 1'b0;
    logic [23:0] pix_data  = '0;
    logic        a_start   = 1'b0;
    logic        a_wrn     = 1'b1;
    logic        b_start   = 1'b0;
    logic        b_wrn     = 1'b1;

    logic [26:0] a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_wr, a_bb, a_busy, a_done, a_ovf;
    logic        b_wr, b_bb, b_busy, b_done, b_ovf;
    logic [2:0]  a_size, b_size;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [58:0] qa[$];
    logic [58:0] qb[$];

    always #5 clk = ~clk;

    avl_frame_writer #(.BASE_ADDR(BASE), .FRAME_WORDS(NPIX), .FIFO_AW(6)) u_dut_a (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(a_start), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .local_init_done(init_done), .avl_waitrequest_n(a_wrn),
        .avl_address(a_addr), .avl_writedata(a_data), .avl_write(a_wr), .avl_burstbegin(a_bb),
        .avl_size(a_size), .busy(a_busy), .done(a_done), .overflow(a_ovf)
    );

    avl_frame_writer #(.BASE_ADDR(BASE), .FRAME_WORDS(NPIX), .FIFO_AW(2)) u_dut_b (
        .iCLK(clk), .iRST_n(rst_n), .iSTART(b_start), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .local_init_done(init_done), .avl_waitrequest_n(b_wrn),
        .avl_address(b_addr), .avl_writedata(b_data), .avl_write(b_wr), .avl_burstbegin(b_bb),
        .avl_size(b_size), .busy(b_busy), .done(b_done), .overflow(b_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Bus monitors: hold checks while stalled, burstbegin on first presentation, scoreboard pop.
    logic        a_st = 1'b0;
    logic [26:0] a_pa;
    logic [31:0] a_pd;
    always @(negedge clk) begin
        logic [58:0] e;
        if (!rst_n) begin
            a_st = 1'b0;
        end else begin
            if (a_st) begin
                check_val("a_hold_write", a_wr, 1);
                check_val("a_hold_addr", {5'd0, a_addr}, {5'd0, a_pa});
                check_val("a_hold_data", a_data, a_pd);
                check_val("a_burstbegin_repeat", a_bb, 0);
            end else if (a_wr) begin
                check_val("a_burstbegin_first", a_bb, 1);
            end
            if (a_wr && a_wrn) begin
                if (qa.size() == 0) begin
                    check_val("a_unexpected_write", {5'd0, a_addr}, 32'hffff_ffff);
                end else begin
                    e = qa.pop_front();
                    check_val("a_addr", {5'd0, a_addr}, {5'd0, e[58:32]});
                    check_val("a_data", a_data, e[31:0]);
                end
            end
            a_st = a_wr && !a_wrn;
            a_pa = a_addr;
            a_pd = a_data;
        end
    end

    logic        b_st = 1'b0;
    logic [26:0] b_pa;
    logic [31:0] b_pd;
    always @(negedge clk) begin
        logic [58:0] e;
        if (!rst_n) begin
            b_st = 1'b0;
        end else begin
            if (b_st) begin
                check_val("b_hold_write", b_wr, 1);
                check_val("b_hold_addr", {5'd0, b_addr}, {5'd0, b_pa});
                check_val("b_hold_data", b_data, b_pd);
                check_val("b_burstbegin_repeat", b_bb, 0);
            end else if (b_wr) begin
                check_val("b_burstbegin_first", b_bb, 1);
            end
            if (b_wr && b_wrn) begin
                if (qb.size() == 0) begin
                    check_val("b_unexpected_write", {5'd0, b_addr}, 32'hffff_ffff);
                end else begin
                    e = qb.pop_front();
                    check_val("b_addr", {5'd0, b_addr}, {5'd0, e[58:32]});
                    check_val("b_data", b_data, e[31:0]);
                end
            end
            b_st = b_wr && !b_wrn;
            b_pa = b_addr;
            b_pd = b_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dut(input bit to_b);
        if (to_b) b_start = 1'b1;
        else a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // a_keep/b_keep: how many leading frame pixels each instance is expected to write.
    task automatic send_frame(input int n_pre, input int a_keep, input int b_keep,
                              input bit a_stall, input bit mid_start);
        for (int i = 0; i < n_pre; i++) begin
            pix_valid = 1'b1;
            pix_sof   = 1'b0;
            pix_data  = 24'hBB0000 + 24'(i);
            cyc();
        end
        for (int i = 0; i < NPIX; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_data  = 24'hA00000 + 24'(i);
            a_start   = mid_start && (i == 8);
            if (a_stall) a_wrn = !(i >= 4 && i < 14);
            if (i < a_keep) qa.push_back({BASE + 27'(i), 8'h00, pix_data});
            if (i < b_keep) qb.push_back({BASE + 27'(i), 8'h00, pix_data});
            cyc();
            if (mid_start && i == 8) check_val("a_busy_after_mid_start", a_busy, 1);
        end
        a_start = 1'b0;
        if (a_stall) a_wrn = 1'b1;
        // Pixels past the frame end, one flagged sof, must be ignored.
        for (int k = 0; k < 2; k++) begin
            pix_valid = 1'b1;
            pix_sof   = (k == 0);
            pix_data  = 24'hCC0000 + 24'(k);
            cyc();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_done(input bit is_b, input logic exp_ovf);
        int n = 0;
        while (!(is_b ? b_done : a_done) && n < 300) begin
            cyc();
            n++;
        end
        if (is_b) begin
            check_val("b_done", b_done, 1);
            check_val("b_busy_at_done", b_busy, 0);
            check_val("b_overflow", b_ovf, exp_ovf);
            check_val("b_queue_drained", qb.size(), 0);
        end else begin
            check_val("a_done", a_done, 1);
            check_val("a_busy_at_done", a_busy, 0);
            check_val("a_overflow", a_ovf, exp_ovf);
            check_val("a_queue_drained", qa.size(), 0);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        check_val("rst_write", a_wr, 0);
        check_val("rst_burstbegin", a_bb, 0);
        check_val("rst_addr", {5'd0, a_addr}, {5'd0, BASE});
        check_val("rst_writedata", a_data, 0);
        check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_overflow", a_ovf, 0);
        check_val("size_const", {29'd0, a_size}, 1);
        check_val("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        cyc();

        // Start before the controller is initialised stays in IDLE.
        start_dut(0);
        check_val("noinit_busy", a_busy, 0);
        check_val("noinit_done", a_done, 0);
        cyc();
        check_val("noinit_busy_later", a_busy, 0);
        init_done = 1'b1;

        start_dut(0);
        check_val("a_busy_wait_sof", a_busy, 1);
        send_frame(0, NPIX, 0, 1'b0, 1'b0);
        wait_done(0, 1'b0);

        start_dut(0);
        send_frame(5, NPIX, 0, 1'b0, 1'b0);
        wait_done(0, 1'b0);

        start_dut(0);
        send_frame(0, NPIX, 0, 1'b1, 1'b1);
        wait_done(0, 1'b0);

        // Output register plus four FIFO entries fill under a full stall: pixels 0..4 survive.
        b_wrn = 1'b0;
        start_dut(1);
        send_frame(0, 0, 5, 1'b0, 1'b0);
        repeat (4) cyc();
        b_wrn = 1'b1;
        wait_done(1, 1'b1);

        // Reset mid-capture with a stalled write in flight.
        start_dut(0);
        a_wrn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_data  = 24'hDD0000 + 24'(i);
            cyc();
        end
        check_val("a_write_inflight", a_wr, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_write", a_wr, 0);
        check_val("midrst_burstbegin", a_bb, 0);
        check_val("midrst_busy", a_busy, 0);
        check_val("midrst_done", a_done, 0);
        check_val("midrst_addr", {5'd0, a_addr}, {5'd0, BASE});
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        a_wrn     = 1'b1;
        qa.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check_val("postrst_busy", a_busy, 0);
        start_dut(0);
        send_frame(0, NPIX, 0, 1'b0, 1'b0);
        wait_done(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/avl_frame_writer.md
Name: avl_frame_writer

Overview:
- Captures one video frame from the receive-side pixel stream and writes it into LPDDR2 through multiport Avalon write port 0.
- This is the write-side counterpart of the video generator's port-1 read path: pixels land at the addresses the generator later reads back.
- Runs in the afi_half_clk domain. The upstream pixel stream is already synchronised to iCLK.
- Buffers pixels in a small FIFO to absorb waitrequest stalls. Reports done, busy and overflow status.

Parameters:
- BASE_ADDR, 27'h0, word address of the first pixel.
- FRAME_WORDS, 2073600, pixels per frame (1920x1080). Minimum 1.
- FIFO_AW, 6, FIFO address width. Depth is 2**FIFO_AW.

Ports:
- iCLK  in  1  Avalon/afi_half_clk clock.
- iRST_n  in  1  asynchronous active-low reset.
- iSTART  in  1  single-cycle pulse that arms a capture. Ignored unless in IDLE or DONE.
- pix_valid  in  1  pixel qualifier. Cannot be back-pressured.
- pix_sof  in  1  first pixel of frame, qualified by pix_valid.
- pix_data  in  24  RGB pixel.
- local_init_done  in  1  LPDDR2 controller initialised.
- avl_waitrequest_n  in  1  port ready.
- avl_address  out  27  word address.
- avl_writedata  out  32  {8'h00, pix_data}.
- avl_write  out  1  write request.
- avl_burstbegin  out  1  burst start.
- avl_size  out  3  burstcount. Constant 3'b001.
- busy  out  1  high in WAIT_SOF, CAPTURE and DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky. Set if any pixel is dropped during the current capture.

Behaviour:
- Reset values: avl_write=0, avl_burstbegin=0, avl_address=BASE_ADDR, avl_writedata=0, busy=0, done=0, overflow=0. FIFO is empty, all counters are 0, state is IDLE.
- IDLE / DONE + iSTART=1 + local_init_done=1 -> WAIT_SOF. On this transition: clear overflow, zero the pixel counter and write counter, flush the FIFO.
- iSTART while local_init_done=0 is ignored.
- WAIT_SOF: pixels are discarded.
  - pix_valid & pix_sof -> that pixel is pushed into the FIFO, pixel counter becomes 1, state goes to CAPTURE.
  - If FRAME_WORDS=1, go straight to DRAIN instead.
- CAPTURE: every pix_valid pixel increments the pixel counter.
  - If the FIFO is not full, the pixel is pushed.
  - If the FIFO is full, the pixel is dropped and overflow is set.
  - pix_sof inside CAPTURE is treated as an ordinary pixel. There is no resync.
  - When the counter reaches FRAME_WORDS on a pixel, move to DRAIN on the next cycle. Later pixels are ignored.
- DRAIN: no pushes. When the FIFO is empty and no write is outstanding -> DONE.
- DONE holds until the next iSTART.
- Write engine (independent of the capture FSM, active whenever the FIFO is non-empty):
  - Pop one word into the output register.
  - Assert avl_write=1 and avl_burstbegin=1 the following cycle, with avl_address = BASE_ADDR + write counter.
  - avl_burstbegin is high only on the first cycle the request is presented.
  - avl_write, avl_address and avl_writedata stay stable while avl_waitrequest_n=0.
  - The transfer completes on a cycle with avl_write=1 & avl_waitrequest_n=1. On that cycle the write counter increments.
  - The next word may be presented on the very next cycle, giving back-to-back writes at 1 word/cycle when never stalled.
- Address arithmetic: 27-bit, wraps modulo 2**27. Pixels dropped on overflow consume no address.
- Simultaneous push and pop on the same cycle are both honoured. Full is evaluated before the same-cycle pop, so the design is conservative.
- Pixel-to-write latency: a pixel pushed in cycle N appears on avl_write no earlier than cycle N+2.
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight Avalon write is abandoned. Controller-side consequences are accepted.
- local_init_done falling mid-capture: no special handling.

Decomposition:
- Shared package holds:
  - AVL_AW=27 and AVL_DW=32.
  - the 3'b001 burstcount constant.
  - the pixel packing rule (8'h00 pad on the upper byte).
  - the state enum {IDLE, WAIT_SOF, CAPTURE, DRAIN, DONE}.
  - the 1080p frame size constant, which the video generator also uses.
- One sub-module: avl_wr_fifo.
  - Synchronous single-clock FIFO, 24 bits wide, depth 2**FIFO_AW.
  - Ports: push, pop, full, empty, flush.
  - Registered output, 1-cycle read latency.

Test Plan:
- FRAME_WORDS=16, BASE_ADDR=27'h100, avl_waitrequest_n tied 1, pix_sof on pixel 0xA00000, 16 consecutive incrementing pixels -> 16 writes, addresses 0x100..0x10F, writedata 0x00A00000..0x00A0000F, done=1, overflow=0.
- Same stimulus with 5 pixels presented before pix_sof -> those 5 are not written. Capture starts exactly at the sof pixel.
- avl_waitrequest_n held low for 10 cycles mid-frame -> request signals stable throughout, avl_burstbegin high only on the first cycle, no duplicated or lost words.
- FIFO_AW=2, waitrequest_n low for 20 cycles during 16 continuous pixels -> overflow=1. Writes issued = 16 − dropped, at contiguous addresses from BASE_ADDR. done=1.
- iSTART with local_init_done=0 -> state remains IDLE, busy=0. iSTART during CAPTURE is ignored.
- iRST_n pulsed low during CAPTURE -> avl_write=0, busy=0, done=0 immediately. A fresh iSTART then captures a full frame starting at BASE_ADDR.
